// File: rtl/mem_port_arb_pkg.sv
// rtl/mem_port_arb_pkg.sv - shared constants and strobe helper for mem_port_arb
//
// Purpose: state encoding, requester count, phase counter width and the
// per-state memory strobe table used by the arbiter top.
// Ports: none (package).
package mem_port_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE1 = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_STROBE2 = 3'd4;
  localparam logic [2:0] ST_TAIL    = 3'd5;

  typedef struct packed {
    logic ce;
    logic csb;
    logic web;
    logic oeb;
  } strobe_t;

  localparam strobe_t STRB_IDLE = '{ce: 1'b0, csb: 1'b1, web: 1'b1, oeb: 1'b1};

  // Strobe levels to present while in state st for an access of direction we.
  function automatic strobe_t phase_strobes(input logic [2:0] st, input logic we);
    strobe_t s;
    s = STRB_IDLE;
    case (st)
      ST_SETUP:   s = '{ce: 1'b0, csb: 1'b0, web: ~we,  oeb: we};
      ST_STROBE1: s = '{ce: 1'b1, csb: 1'b0, web: ~we,  oeb: we};
      ST_GAP:     s = '{ce: 1'b0, csb: 1'b1, web: 1'b1, oeb: we};
      ST_STROBE2: s = '{ce: 1'b1, csb: 1'b1, web: 1'b1, oeb: 1'b1};
      default:    s = STRB_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_port_arb_rr_arb2.sv
// rtl/mem_port_arb_rr_arb2.sv - two-way round-robin pick
//
// Purpose: chooses one of two requesters; on a tie the requester favoured by
// the pointer wins, and the pointer moves to the other requester when take=1.
// Ports: clk, rst (async high); req[1:0] requests; take = grant issued this
// edge; winner = chosen index; any = at least one request present.
module rr_arb2
  import mem_port_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic               winner,
  output logic               any
);

  // Requester favoured on a tie; it is the one not served last.
  logic pref;

  assign any = |req;

  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = pref;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref <= 1'b0;
    end else if (take) begin
      pref <= ~winner;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - two-port arbiter driving a strobed memory controller
//
// Purpose: grants one of two requesters, then sequences SETUP, STROBE1, GAP,
// STROBE2 and TAIL (each strobe phase STRB_CYC cycles) and pulses ACK.
// Ports: clk, rst (async high); req/we/addr/wdata per requester; gnt/ack per
// requester; rdata; bist_busy blocks new grants; busy; m_* memory side.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int STRB_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  input  logic        bist_busy,
  output logic        busy,
  output logic        m_ce,
  output logic        m_csb,
  output logic        m_web,
  output logic        m_oeb,
  output logic [15:0] m_addr,
  output logic [7:0]  m_idata,
  input  logic [7:0]  m_odata
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(STRB_CYC - 1);

  logic [2:0]       state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic             grant, win, win_any;
  logic             owner, lat_we;
  logic             nowner, nwe, ack_n;
  strobe_t          strb;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1, req0}),
    .take   (grant),
    .winner (win),
    .any    (win_any)
  );

  assign grant = (state == ST_IDLE) && !bist_busy && win_any;

  // Each phase reloads the counter on entry and leaves when it reaches zero.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          nstate = ST_SETUP;
          ncnt   = '0;
        end
      end
      ST_SETUP: begin
        nstate = ST_STROBE1;
        ncnt   = LOAD;
      end
      ST_STROBE1, ST_GAP, ST_STROBE2: begin
        if (cnt == '0) begin
          nstate = state + 3'd1;
          ncnt   = LOAD;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      ST_TAIL: begin
        if (cnt == '0) begin
          nstate = ST_IDLE;
          ncnt   = '0;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      default: begin
        nstate = ST_IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  assign nowner = grant ? win : owner;
  assign nwe    = grant ? (win ? we1 : we0) : lat_we;
  assign ack_n  = (nstate == ST_TAIL) && (ncnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      owner   <= 1'b0;
      lat_we  <= 1'b0;
      m_addr  <= '0;
      m_idata <= '0;
      strb    <= STRB_IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      if (grant) begin
        owner   <= win;
        lat_we  <= win ? we1 : we0;
        m_addr  <= win ? addr1 : addr0;
        m_idata <= win ? wdata1 : wdata0;
      end
      strb <= phase_strobes(nstate, nwe);
      gnt0 <= (nstate != ST_IDLE) && !nowner;
      gnt1 <= (nstate != ST_IDLE) && nowner;
      ack0 <= ack_n && !nowner;
      ack1 <= ack_n && nowner;
      busy <= nstate != ST_IDLE;
      if ((state == ST_GAP) && (cnt == '0) && !lat_we) begin
        rdata <= m_odata;
      end
    end
  end

  assign m_ce  = strb.ce;
  assign m_csb = strb.csb;
  assign m_web = strb.web;
  assign m_oeb = strb.oeb;

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter: STRB_CYC, default 1, clock cycles spent in each CE phase (STROBE1, GAP, STROBE2, TAIL); legal range 1..15.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ0/REQ1  input  1 each  access request from requester 0/1.
REQ-005 WE0/WE1  input  1 each  1 = write, 0 = read.
REQ-006 ADDR0/ADDR1  input  16 each  request address.
REQ-007 WDATA0/WDATA1  input  8 each  write data.
REQ-008 GNT0/GNT1  output  1 each  one-hot grant, held high from SETUP through TAIL.
REQ-009 ACK0/ACK1  output  1 each  single-cycle completion pulse.
REQ-010 RDATA  output  8  read data, valid while ACKx is high for a read.
REQ-011 BIST_BUSY  input  1  when high, no new grant is issued.
REQ-012 BUSY  output  1  high whenever state is not IDLE.
REQ-013 M_CE, M_CSB, M_WEB, M_OEB  output  1 each  memory-controller strobes.
REQ-014 M_ADDR  output  16  and  M_IDATA  output  8  memory-controller address and data.
REQ-015 M_ODATA  input  8  memory-controller read data.

Function
REQ-016 States: IDLE, SETUP, STROBE1, GAP, STROBE2, TAIL; every output is registered.
REQ-017 IDLE: with BIST_BUSY=0 and any REQx=1 at a clock edge, the block moves to SETUP, latches the winner's WE, ADDR and WDATA, and raises GNTx.
REQ-018 Arbitration is round-robin through a last-served pointer: a single requester wins; when both request, the one not served last wins; after reset, requester 0 wins.
REQ-019 SETUP (1 cycle): M_CSB=0, M_WEB=~WE, M_OEB=WE, M_CE=0, M_ADDR and M_IDATA driven from the latched fields.
REQ-020 STROBE1 (STRB_CYC cycles): M_CE=1; M_CSB, M_WEB and M_OEB keep their SETUP values.
REQ-021 GAP (STRB_CYC cycles): M_CE=0, M_CSB=1, M_WEB=1; M_OEB keeps its SETUP value.
REQ-022 On the edge leaving GAP, M_ODATA is captured into RDATA for reads; for writes RDATA keeps its previous value.
REQ-023 STROBE2 (STRB_CYC cycles): M_CE=1, M_OEB=1.
REQ-024 TAIL (STRB_CYC cycles): M_CE=0; ACKx=1 during the final TAIL cycle only; the next state is IDLE.
REQ-025 Transaction length is 1+4*STRB_CYC cycles from the grant edge; at least one IDLE cycle separates consecutive transactions.
REQ-026 The phase counter is 4 bits wide, reloads on every state entry, and does not wrap.
REQ-027 Latched fields are immune to input changes after grant; REQx dropping mid-transaction does not abort it, and ACKx is still issued.
REQ-028 BIST_BUSY rising mid-transaction: the current transaction completes; no grant is issued while BIST_BUSY=1.
REQ-029 A REQx arriving outside IDLE waits; the pointer updates only at grant.

Reset
REQ-030 RST=1 immediately forces: state IDLE, pointer selecting requester 0, M_CE=0, M_CSB=1, M_WEB=1, M_OEB=1, M_ADDR=0, M_IDATA=0, GNTx=0, ACKx=0, RDATA=0, BUSY=0.
REQ-031 Reset mid-transaction abandons the transaction with no ACK; strobes return to their inactive values without waiting for a clock edge.

Structure
REQ-032 The shared package holds the state encoding constants, the requester count (2) and the phase counter width (4).
REQ-033 One sub-module, rr_arb2: a two-way round-robin pick with pointer update on grant.

Verification
REQ-034 Single write, STRB_CYC=1: REQ0=1, WE0=1, ADDR0=16'h1234, WDATA0=8'hA5 -> SETUP drives M_CSB=0/M_WEB=0; CE pulses 1,0,1,0; ACK0 5 cycles after the grant edge.
REQ-035 Read-after-write: write 8'h3C to address 16'h00FF, then REQ1 reads 16'h00FF -> RDATA=8'h3C with ACK1; M_OEB=0 from SETUP through GAP.
REQ-036 Contention: REQ0 and REQ1 both held high continuously -> grants alternate 0,1,0,1 after reset; each ACK is 1 cycle wide.
REQ-037 BIST_BUSY=1 raised during STROBE1 -> current ACK still occurs; REQ1 remains pending until BIST_BUSY=0.
REQ-038 RST pulsed during GAP -> strobes inactive immediately, no ACK issued, and the next request goes to requester 0.
REQ-039 STRB_CYC=3: a read completes in 13 cycles; each CE phase lasts 3 cycles; ACK coincides with the last TAIL cycle.
